// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction-memory request/ack bus between the sequencer
//               (master) and the instruction memory (slave).
//                 req   - fetch request, held until ack
//                 addr  - word address of the requested instruction
//                 ack   - memory accepts and returns data this cycle
//                 rdata - instruction word, valid with ack
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Multi-cycle instruction sequencer for the KGPRisc core.
//               Owns the PC and steps IDLE -> FETCH -> DECODE -> EXEC ->
//               UPDATE -> FETCH ..., or into HALT on a halting instruction.
//               Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               run             - leave IDLE and start fetching
//               imem (master)   - instruction memory req/addr/ack/rdata
//               instr           - latched instruction word
//               instr_valid     - one-cycle pulse, instr ready for decode
//               ex_done         - execute finished current instruction
//               branch_taken    - with ex_done: load branch_target
//               branch_target   - next PC when branch_taken
//               halt            - with ex_done: stop after this instruction
//               pc              - current PC
//               halted          - sequencer is in HALT
//               fetch_err       - watchdog fired (sticky), 0 when disabled
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              TIMEOUT_CYC = 15
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              run,
  fetch_sequencer_if.master      imem,
  output logic [DATA_W-1:0]      instr,
  output logic                   instr_valid,
  input  wire logic              ex_done,
  input  wire logic              branch_taken,
  input  wire logic [ADDR_W-1:0] branch_target,
  input  wire logic              halt,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted,
  output logic                   fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] c_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_br_taken;
  logic [ADDR_W-1:0] r_br_target;
  logic              r_halt;
  logic              w_to_expire;   // watchdog limit reached without ack

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_FETCH;
      // An ack on the watchdog limit cycle wins over the timeout.
      S_FETCH: begin
        if (imem.ack)         w_state_nxt = S_DECODE;
        else if (w_to_expire) w_state_nxt = S_HALT;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   if (ex_done) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = r_halt ? S_HALT : S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: instruction latch, execute result capture, PC update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_VEC;
      r_instr     <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_halt      <= 1'b0;
    end else begin
      if (r_state == S_FETCH && imem.ack) begin
        r_instr <= imem.rdata;
      end
      // Branch/halt inputs are only meaningful alongside ex_done in EXEC,
      // so they are captured here and consumed in UPDATE.
      if (r_state == S_EXEC && ex_done) begin
        r_br_taken  <= branch_taken;
        r_br_target <= branch_target;
        r_halt      <= halt;
      end
      if (r_state == S_UPDATE) begin
        r_pc <= r_br_taken ? r_br_target : r_pc + c_PC_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch watchdog
  // --------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [c_CNT_W-1:0] r_to_cnt;   // FETCH cycles so far without ack
  logic               r_fetch_err;

  assign w_to_expire = (r_state == S_FETCH) && !imem.ack &&
                       (r_to_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt    <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_state_nxt == S_FETCH && r_state != S_FETCH) begin
        r_to_cnt <= '0;
      end else if (r_state == S_FETCH && !imem.ack) begin
        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
      end
      if (w_to_expire) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_to_expire = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs: registers or decodes of the state register only
  // --------------------------------------------------------------------------
  assign imem.req    = (r_state == S_FETCH);
  assign imem.addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_DECODE);
  assign pc          = r_pc;
  assign halted      = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. Instance A runs
//               from PC 0 through linear, branch, stall, halt and reset
//               sequences; instance B starts at the all-ones PC to exercise
//               the wrap into HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A (RESET_VEC = 0) ----------------
  logic        run_a = 1'b0, ack_a = 1'b0, ex_done_a = 1'b0;
  logic        br_taken_a = 1'b0, halt_a = 1'b0;
  logic [31:0] br_target_a = '0;
  logic [31:0] instr_a, pc_a;
  logic        instr_valid_a, halted_a, fetch_err_a;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) imem_a ();
  assign imem_a.ack   = ack_a;
  assign imem_a.rdata = imem_a.addr ^ 32'hDEAD_0000;

  fetch_sequencer #(.ADDR_W(32), .DATA_W(32), .RESET_VEC(32'h0), .TIMEOUT_CYC(15)) u_dut_a (
    .clk(clk), .reset(reset), .run(run_a), .imem(imem_a),
    .instr(instr_a), .instr_valid(instr_valid_a), .ex_done(ex_done_a),
    .branch_taken(br_taken_a), .branch_target(br_target_a), .halt(halt_a),
    .pc(pc_a), .halted(halted_a), .fetch_err(fetch_err_a)
  );

  // ---------------- instance B (RESET_VEC = all ones) ----------------
  logic        run_b = 1'b0, ex_done_b = 1'b0, halt_b = 1'b0;
  logic [31:0] instr_b, pc_b;
  logic        instr_valid_b, halted_b, fetch_err_b;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) imem_b ();
  assign imem_b.ack   = imem_b.req;
  assign imem_b.rdata = 32'h1234_5678;

  fetch_sequencer #(.ADDR_W(32), .DATA_W(32), .RESET_VEC(32'hFFFF_FFFF), .TIMEOUT_CYC(15)) u_dut_b (
    .clk(clk), .reset(reset), .run(run_b), .imem(imem_b),
    .instr(instr_b), .instr_valid(instr_valid_b), .ex_done(ex_done_b),
    .branch_taken(1'b0), .branch_target(32'h0), .halt(halt_b),
    .pc(pc_b), .halted(halted_b), .fetch_err(fetch_err_b)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_instr[$];
  int          cyc = 0;
  int          last_valid_cyc = 0;
  bit          gap_check = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever A presents an accepted fetch or
  // a decode pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_a.req && ack_a) begin
        if (q_addr.size() == 0) chk("fetch_unexpected", imem_a.addr, 32'hXXXX_XXXX);
        else                    chk("fetch_addr", imem_a.addr, q_addr.pop_front());
      end
      if (instr_valid_a) begin
        if (q_instr.size() == 0) chk("valid_unexpected", instr_a, 32'hXXXX_XXXX);
        else                     chk("instr", instr_a, q_instr.pop_front());
        if (gap_check) chk("valid_gap", cyc - last_valid_cyc, 32'd4);
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_a();
    int k = 0;
    while (!imem_a.req && k < 8) begin
      tick();
      k++;
    end
    chk("fetch_req", {31'b0, imem_a.req}, 32'd1);
  endtask

  // One instruction on A, starting in (or just before) its FETCH cycle and
  // returning in the cycle after UPDATE.
  task automatic do_instr(input logic [31:0] exp_addr, input logic [31:0] exp_instr,
                          input int ack_wait, input int ex_wait,
                          input logic tk, input logic [31:0] tgt, input logic h);
    q_addr.push_back(exp_addr);
    q_instr.push_back(exp_instr);
    wait_req_a();
    for (int i = 0; i < ack_wait; i++) begin
      ack_a = 1'b0;
      tick();
      chk("stall_req", {31'b0, imem_a.req}, 32'd1);
      chk("stall_addr", imem_a.addr, exp_addr);
      chk("stall_novalid", {31'b0, instr_valid_a}, 32'd0);
    end
    ack_a = 1'b1;
    tick();                                   // DECODE
    ack_a = 1'b0;
    tick();                                   // EXEC
    for (int j = 0; j < ex_wait; j++) begin
      ex_done_a = 1'b0;
      tick();
      chk("exec_pc_hold", pc_a, exp_addr);
    end
    ex_done_a = 1'b1; br_taken_a = tk; br_target_a = tgt; halt_a = h;
    tick();                                   // UPDATE
    ex_done_a = 1'b0; br_taken_a = ~tk; br_target_a = 32'hFFFF_FFF0; halt_a = 1'b0;
    chk("update_pc_old", pc_a, exp_addr);
    tick();                                   // FETCH or HALT
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset / idle ----------------
    tick(); tick(); tick();
    chk("rst_instr", instr_a, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_a}, 32'd0);
    chk("rst_err", {31'b0, fetch_err_a}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_pc", pc_a, 32'h0);
      chk("idle_req", {31'b0, imem_a.req}, 32'd0);
      chk("idle_halted", {31'b0, halted_a}, 32'd0);
    end

    // ---------------- linear run, branches, stalls, halt ----------------
    run_a = 1'b1;
    tick();
    chk("start_req", {31'b0, imem_a.req}, 32'd1);
    do_instr(32'h0, 32'hDEAD_0000, 0, 0, 1'b0, 32'h0, 1'b0);
    gap_check = 1'b1;
    do_instr(32'h1, 32'hDEAD_0001, 0, 0, 1'b0, 32'h0, 1'b0);
    do_instr(32'h2, 32'hDEAD_0002, 0, 0, 1'b0, 32'h0, 1'b0);
    do_instr(32'h3, 32'hDEAD_0003, 0, 0, 1'b0, 32'h0, 1'b0);
    do_instr(32'h4, 32'hDEAD_0004, 0, 0, 1'b1, 32'h2, 1'b0);
    do_instr(32'h2, 32'hDEAD_0002, 0, 0, 1'b1, 32'h40, 1'b0);
    do_instr(32'h40, 32'hDEAD_0040, 0, 0, 1'b0, 32'h0, 1'b0);
    gap_check = 1'b0;
    do_instr(32'h41, 32'hDEAD_0041, 5, 3, 1'b0, 32'h0, 1'b0);
    do_instr(32'h42, 32'hDEAD_0042, 0, 0, 1'b0, 32'h0, 1'b1);
    chk("halt_halted", {31'b0, halted_a}, 32'd1);
    chk("halt_pc", pc_a, 32'h43);
    chk("halt_instr_hold", instr_a, 32'hDEAD_0042);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_noreq", {31'b0, imem_a.req}, 32'd0);
    end

    // ---------------- reset from HALT, reset mid-FETCH ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rehalt_pc", pc_a, 32'h0);
    chk("rehalt_halted", {31'b0, halted_a}, 32'd0);
    wait_req_a();
    ack_a = 1'b0;
    tick();
    reset = 1'b1; ack_a = 1'b1;
    tick();
    chk("midrst_req", {31'b0, imem_a.req}, 32'd0);
    chk("midrst_instr", instr_a, 32'h0);
    reset = 1'b0; run_a = 1'b0; ack_a = 1'b0;
    tick();
    chk("midrst_idle", {31'b0, imem_a.req}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // ---------------- watchdog ----------------
    run_a = 1'b1;
    wait_req_a();
    repeat (14) tick();
    q_addr.push_back(32'h0);
    q_instr.push_back(32'hDEAD_0000);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("to_ack15_valid", {31'b0, instr_valid_a}, 32'd1);
    chk("to_ack15_err", {31'b0, fetch_err_a}, 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    wait_req_a();
    repeat (15) tick();
    chk("to_err", {31'b0, fetch_err_a}, 32'd1);
    chk("to_halted", {31'b0, halted_a}, 32'd1);
    chk("to_req", {31'b0, imem_a.req}, 32'd0);
`else
    // ---------------- no watchdog: fetch waits indefinitely ----------------
    run_a = 1'b1;
    wait_req_a();
    repeat (20) tick();
    chk("nto_req", {31'b0, imem_a.req}, 32'd1);
    chk("nto_err", {31'b0, fetch_err_a}, 32'd0);
    chk("nto_halted", {31'b0, halted_a}, 32'd0);
`endif
    run_a = 1'b0;

    // ---------------- instance B: all-ones PC wraps on halt ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    chk("b_rst_pc", pc_b, 32'hFFFF_FFFF);
    run_b = 1'b1;
    tick();                                   // FETCH (acked immediately)
    chk("b_fetch_addr", imem_b.addr, 32'hFFFF_FFFF);
    tick();                                   // DECODE
    chk("b_valid", {31'b0, instr_valid_b}, 32'd1);
    chk("b_instr", instr_b, 32'h1234_5678);
    tick();                                   // EXEC
    ex_done_b = 1'b1; halt_b = 1'b1;
    tick();                                   // UPDATE
    ex_done_b = 1'b0; halt_b = 1'b0;
    tick();                                   // HALT
    chk("b_wrap_pc", pc_b, 32'h0);
    chk("b_halted", {31'b0, halted_b}, 32'd1);
    chk("b_err", {31'b0, fetch_err_b}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b_run_ignored", {31'b0, imem_b.req}, 32'd0);
    end

    chk("sb_addr_left", q_addr.size(), 32'd0);
    chk("sb_instr_left", q_instr.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction sequencer for the KGPRisc core. It owns the program-counter value and steps the core through fetch, decode, execute and PC-update phases. It drives the instruction-memory request handshake, latches the fetched word, and hands it to decode. It then chooses between sequential advance and a branch target when execute completes.

## Interface
- ADDR_W, 32, PC / instruction-address width (word addressed)
- DATA_W, 32, instruction word width
- RESET_VEC, 0, PC value loaded at reset
- TIMEOUT_CYC, 15, fetch watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- run  in  1  leave IDLE and start fetching
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  memory accepts and returns data this cycle
- imem_rdata  in  DATA_W  instruction word, valid with imem_ack
- instr  out  DATA_W  latched instruction
- instr_valid  out  1  one-cycle pulse: instr ready for decode
- ex_done  in  1  execute stage finished current instruction
- branch_taken  in  1  sampled with ex_done: load branch_target
- branch_target  in  ADDR_W  next PC when branch_taken
- halt  in  1  sampled with ex_done: stop after this instruction
- pc  out  ADDR_W  current PC
- halted  out  1  sequencer in HALT
- fetch_err  out  1  watchdog fired (sticky; 0 when macro off)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- **IDLE:** outputs quiescent. Goes to FETCH when run=1.
- **FETCH:** imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, then go to DECODE.
  - Without ack, stay in FETCH with req held.
- **DECODE:** instr_valid=1 for exactly this cycle. Always goes to EXEC.
- **EXEC:** waits for ex_done.
  - On ex_done, latch branch_taken, branch_target and halt into internal registers, then go to UPDATE.
- **UPDATE:** pc<=taken ? target : pc+1.
  - pc+1 is modulo 2^ADDR_W: all-ones wraps to 0.
  - If the latched halt is set, go to HALT (pc still updated); otherwise go to FETCH.
- **HALT:** halted=1. Stays there until reset; run is ignored.
- branch_taken, branch_target and halt are don't-care outside the EXEC cycle in which ex_done=1.
- imem_ack outside FETCH is ignored. ex_done outside EXEC is ignored.
- instr holds its value until the next accepted fetch.

## Timing
- **Reset values:** state=IDLE, pc=RESET_VEC, instr=0, imem_req=0, instr_valid=0, halted=0, fetch_err=0.
- Reset has priority in every state. Mid-fetch it drops imem_req on the next edge, and any ack arriving in that cycle is discarded.
- All outputs are registered or pure decodes of the state register; there are no combinational paths from inputs to outputs.
- **Minimum rate:** 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE) with ack and ex_done both immediate.
- Each extra cycle without ack adds one FETCH cycle. Each extra cycle without ex_done adds one EXEC cycle.
- **Start:** run sampled high in IDLE at edge N gives imem_req=1 in cycle N+1.
- The new pc is visible the cycle after UPDATE, which is the same cycle imem_req reasserts.

## Configuration
- **FETCH_TIMEOUT_EN defined:**
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYC with no ack, fetch_err is set (sticky) and the next state is HALT. imem_req drops in that next cycle.
  - An ack on exactly the limit cycle wins: no error.
- **FETCH_TIMEOUT_EN undefined:** there is no counter, fetch_err is tied 0, and FETCH waits indefinitely.

## Test plan
- **Reset / idle:** assert reset with run=0 -> pc=RESET_VEC=0, imem_req=0, halted=0. The outputs hold for 10 cycles.
- **Linear run:** run=1, ack and ex_done immediate, branch_taken=0.
  - imem_addr sequence is 0,1,2,3.
  - instr_valid pulses every 4th cycle, and instr matches imem_rdata.
- **Branch:** at pc=2, ex_done with branch_taken=1 and branch_target=0x40 -> next imem_addr=0x40. The following fetch is 0x41.
- **Stalls:** withhold ack for 5 cycles -> imem_req held with addr stable and no instr_valid. Withhold ex_done for 3 cycles -> pc unchanged until the cycle after ex_done.
- **Halt / wrap:** start with RESET_VEC=all-ones and halt=1 on the first ex_done -> pc=0 and halted=1. A later run=1 produces no fetch.
- **Timeout (macro on):** no ack for 15 cycles -> fetch_err=1, halted=1, imem_req=0. An ack on the 15th cycle -> normal DECODE with fetch_err=0. Reset mid-FETCH -> IDLE, imem_req=0 on the next edge.
